// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared fetch-path types and constants for the 16-bit pipeline
package wisc_pkg;

    localparam int          INSTR_W     = 16;
    localparam logic [15:0] PC_INC      = 16'h0002;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr, input logic [3:0] opcode);
        return instr[INSTR_W-1 -: 4] == opcode;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side bundle: imem port, branch redirect, decode stall, IF/ID outputs
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             imem_ready;
    logic [15:0]      imem_data;
    logic             imem_req;
    logic [15:0]      fetch_pc;
    logic             stall_in;
    logic             redirect_valid;
    logic [15:0]      redirect_target;
    logic [15:0]      ifid_instr;
    logic [15:0]      ifid_pc_plus2;
    logic             ifid_valid;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  imem_ready, imem_data, stall_in, redirect_valid, redirect_target,
        output imem_req, fetch_pc, ifid_instr, ifid_pc_plus2, ifid_valid, flush, halted, stall_cycles
    );

    modport slave (
        output imem_ready, imem_data, stall_in, redirect_valid, redirect_target,
        input  imem_req, fetch_pc, ifid_instr, ifid_pc_plus2, ifid_valid, flush, halted, stall_cycles
    );
endinterface

// File: rtl/adder_16bit.sv
// rtl/adder_16bit.sv - 16-bit modulo adder with carry-in
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    // Carry-out is intentionally dropped: PC arithmetic wraps silently.
    assign sum = a + b + {15'd0, cin};
endmodule

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - fetch_pc + 2, shared by the PC update and the IF/ID link value
module pc_incr
    import wisc_pkg::*;
(
    input  logic [15:0] pc,
    output logic [15:0] pc_plus2
);
    adder_16bit u_add (
        .a   (pc),
        .b   (PC_INC),
        .cin (1'b0),
        .sum (pc_plus2)
    );
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner: FSM over imem wait states, stalls, redirects and HLT
module pc_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int          CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    import wisc_pkg::*;

    fetch_state_t     state, state_nxt;
    logic [15:0]      pc_q, pc_nxt, pc_plus2;
    logic [15:0]      instr_q, instr_nxt;
    logic [15:0]      pc2_q, pc2_nxt;
    logic             valid_q, valid_nxt;
    logic             halted_q, halted_nxt;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q;

    pc_incr u_incr (
        .pc       (pc_q),
        .pc_plus2 (pc_plus2)
    );

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        instr_nxt  = instr_q;
        pc2_nxt    = pc2_q;
        valid_nxt  = valid_q;
        halted_nxt = halted_q;
        if (bus.redirect_valid) begin
            // Redirect wins over everything; any returning word is for the squashed path.
            pc_nxt     = {bus.redirect_target[15:1], 1'b0};
            valid_nxt  = 1'b0;
            halted_nxt = 1'b0;
            state_nxt  = ST_FETCH;
        end else if (bus.stall_in) begin
            if (state != ST_HALT && !bus.imem_ready)
                state_nxt = ST_WAIT;
        end else if (state == ST_HALT) begin
            valid_nxt = 1'b0;
        end else if (bus.imem_ready) begin
            instr_nxt = bus.imem_data;
            pc2_nxt   = pc_plus2;
            valid_nxt = 1'b1;
            if (is_halt(bus.imem_data, HALT_OPCODE)) begin
                state_nxt  = ST_HALT;
                halted_nxt = 1'b1;
            end else begin
                pc_nxt    = pc_plus2;
                state_nxt = ST_FETCH;
            end
        end else begin
            state_nxt = ST_WAIT;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            pc2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            pc2_q    <= pc2_nxt;
            valid_q  <= valid_nxt;
            halted_q <= halted_nxt;
            flush_q  <= bus.redirect_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (state == ST_WAIT && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.imem_req      = (state != ST_HALT);
    assign bus.fetch_pc      = pc_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus2 = pc2_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.flush         = flush_q;
    assign bus.halted        = halted_q;
    assign bus.stall_cycles  = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a cycle-level reference model
module tb_pc_sequencer;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(CW)) bus ();

    pc_sequencer #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic          req;
        logic [15:0]   pc;
        logic [15:0]   instr;
        logic [15:0]   pc2;
        logic          valid;
        logic          flush;
        logic          halted;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: architectural view of the fetch unit.
    logic [15:0] m_pc, m_instr, m_pc2;
    logic        m_valid, m_flush, m_halted, m_waiting;
    int          m_cnt;

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
        m_valid = 1'b0; m_flush = 1'b0; m_halted = 1'b0; m_waiting = 1'b0;
        m_cnt = 0;
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.req = !m_halted; e.pc = m_pc; e.instr = m_instr; e.pc2 = m_pc2;
        e.valid = m_valid; e.flush = m_flush; e.halted = m_halted; e.cnt = CW'(m_cnt);
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("imem_req",      {15'd0, bus.imem_req},   {15'd0, e.req});
        chk("fetch_pc",      bus.fetch_pc,            e.pc);
        chk("ifid_valid",    {15'd0, bus.ifid_valid}, {15'd0, e.valid});
        chk("flush",         {15'd0, bus.flush},      {15'd0, e.flush});
        chk("halted",        {15'd0, bus.halted},     {15'd0, e.halted});
        chk("stall_cycles",  {12'd0, bus.stall_cycles}, {12'd0, e.cnt});
        chk("ifid_instr",    bus.ifid_instr,          e.instr);
        chk("ifid_pc_plus2", bus.ifid_pc_plus2,       e.pc2);
    endtask

    // Drive one cycle of inputs (called at a negedge) and queue the post-edge expectation.
    task automatic step(input logic r, input logic [15:0] tgt, input logic st,
                        input logic rdy, input logic [15:0] data);
        bus.redirect_valid  = r;
        bus.redirect_target = tgt;
        bus.stall_in        = st;
        bus.imem_ready      = rdy;
        bus.imem_data       = data;
        if (m_waiting && m_cnt < CNT_MAX) m_cnt++;
        m_flush = r;
        if (r) begin
            m_pc = tgt & 16'hFFFE; m_valid = 1'b0; m_halted = 1'b0; m_waiting = 1'b0;
        end else if (st) begin
            if (!m_halted && !rdy) m_waiting = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (rdy) begin
            m_instr = data; m_pc2 = m_pc + 16'd2; m_valid = 1'b1; m_waiting = 1'b0;
            if (data[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end else begin
            m_waiting = 1'b1; m_valid = 1'b0;
        end
        exp_q.push_back(model_view());
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk_all(model_view());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each output update after an edge is popped against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk_all(e);
        end
    end

    initial begin
        bus.redirect_valid = 1'b0; bus.redirect_target = 16'h0; bus.stall_in = 1'b0;
        bus.imem_ready = 1'b0; bus.imem_data = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all(model_view());
        rst = 1'b0;

        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 16'h0000);      // pc -> 0x0010
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0000);      // wait states
        step(0, 0, 0, 1, 16'h1234);                                  // delivered, pc 0x0012
        step(0, 0, 0, 0, 16'h0000);
        step(1, 16'h0100, 0, 1, 16'h5555);                           // redirect in WAIT
        step(0, 0, 0, 1, 16'h2222);
        step(1, 16'h0020, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h3333);
        step(0, 0, 1, 1, 16'h4444);                                  // stall, ready ignored
        step(0, 0, 1, 0, 16'h4444);
        step(1, 16'h0040, 1, 1, 16'h6666);                           // redirect beats stall
        step(0, 0, 0, 1, 16'h7777);
        step(1, 16'h0030, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 16'hF000);                                  // HLT
        step(0, 0, 0, 1, 16'h1111);
        step(0, 0, 1, 1, 16'h1111);
        step(0, 0, 0, 1, 16'h1111);
        step(1, 16'h0050, 0, 1, 16'h1111);                           // leave HALT
        step(0, 0, 0, 1, 16'h0101);
        step(1, 16'hFFFE, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h0202);                                  // wrap to 0x0000
        step(1, 16'h0101, 0, 0, 16'h0000);                           // odd target -> 0x0100
        step(0, 0, 0, 1, 16'h0303);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 16'h0000);     // saturate counter
        step(0, 0, 0, 0, 16'h0000);
        async_reset();                                               // reset mid-WAIT
        step(0, 0, 0, 1, 16'hF123);
        step(0, 0, 0, 1, 16'h0000);
        async_reset();                                               // reset mid-HALT
        step(0, 0, 0, 1, 16'h0404);

        for (int i = 0; i < 3000; i++) begin
            logic        r, st, rdy;
            logic [15:0] tgt, data;
            r    = ($urandom_range(0, 9) == 0);
            tgt  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            st   = ($urandom_range(0, 6) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            data = 16'($urandom);
            step(r, tgt, st, rdy, data);
            if (i == 1500) async_reset();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
